// File: rtl/alu_param.sv
// Parameterised handshake ALU: single-cycle arithmetic/logic/shift ops plus a
// W-cycle restoring divider for DIV/MOD, with results held until consumed.
module alu_param #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         zero,
  output logic         carry,
  output logic         ovf,
  output logic         err
);

  localparam int unsigned SW = $clog2(W);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpMul = 4'd2;
  localparam logic [3:0] OpDiv = 4'd3;
  localparam logic [3:0] OpMod = 4'd4;
  localparam logic [3:0] OpAnd = 4'd5;
  localparam logic [3:0] OpOr  = 4'd6;
  localparam logic [3:0] OpXor = 4'd7;
  localparam logic [3:0] OpShl = 4'd8;
  localparam logic [3:0] OpShr = 4'd9;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  res_q, res_d, hi_q, hi_d;
  logic          zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic          mod_q, mod_d;
  logic [SW-1:0] cnt_q, cnt_d;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  logic [W:0]     sum, diff, shl_w, shr_w;
  logic [2*W-1:0] prod;
  logic [SW-1:0]  shamt;
  logic [W-1:0]   alu_res, alu_hi;
  logic           alu_c, alu_v, alu_e;

  assign shamt = b[SW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OpSub: begin
        alu_res = diff[W-1:0];
        alu_c   = diff[W];
        alu_v   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OpMul: begin
        alu_res = prod[W-1:0];
        alu_hi  = prod[2*W-1:W];
        alu_c   = |prod[2*W-1:W];
        alu_v   = |prod[2*W-1:W];
      end
      // Only selected here when the divisor is zero
      OpDiv, OpMod: begin
        alu_res = '1;
        alu_hi  = a;
        alu_e   = 1'b1;
      end
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpXor: alu_res = a ^ b;
      OpShl: {alu_c, alu_res} = shl_w;
      OpShr: {alu_res, alu_c} = shr_w;
      default: alu_e = 1'b1;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  logic [W:0]   rem_sh, trial;
  logic [W-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[W]) begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if ((op == OpDiv || op == OpMod) && b != '0) begin
            state_d = StDiv;
            rem_d   = '0;
            quo_d   = a;
            dvs_d   = b;
            mod_d   = (op == OpMod);
            cnt_d   = '0;
          end else begin
            state_d = StDone;
            res_d   = alu_res;
            hi_d    = alu_hi;
            zero_d  = (alu_res == '0);
            carry_d = alu_c;
            ovf_d   = alu_v;
            err_d   = alu_e;
          end
        end
      end
      StDiv: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(W - 1)) begin
          state_d = StDone;
          res_d   = mod_q ? rem_nx : quo_nx;
          hi_d    = mod_q ? quo_nx : rem_nx;
          zero_d  = ((mod_q ? rem_nx : quo_nx) == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      mod_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
